// File: rtl/block_seq_ctrl_pkg.sv
// Shared definitions for the block sequencing controller: FSM encoding and
// the width of the external block-index register.
package interp_ctrl_pkg;

  localparam int BLK_W = 4;

  localparam logic [2:0] ST_IDLE_C   = 3'd0;
  localparam logic [2:0] ST_CLEAR_C  = 3'd1;
  localparam logic [2:0] ST_RUN_C    = 3'd2;
  localparam logic [2:0] ST_NEXT_C   = 3'd3;
  localparam logic [2:0] ST_FINISH_C = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_C,
    S_CLEAR  = ST_CLEAR_C,
    S_RUN    = ST_RUN_C,
    S_NEXT   = ST_NEXT_C,
    S_FINISH = ST_FINISH_C
  } state_e;

endpackage

// File: rtl/block_seq_ctrl_if.sv
// Handshake and block-index bus between the sequencer and its environment.
interface block_seq_ctrl_if #(
  parameter int ROW_W = 3
);
  logic                             START;
  logic [interp_ctrl_pkg::BLK_W-1:0] NUM_BLOCKS;
  logic                             STALL;
  logic [interp_ctrl_pkg::BLK_W-1:0] COUNT_Q;
  logic                             COUNT_WE;
  logic [interp_ctrl_pkg::BLK_W-1:0] COUNT_D;
  logic                             ROW_VALID;
  logic [ROW_W-1:0]                 ROW_IDX;
  logic                             BUSY;
  logic                             DONE;

  modport master (
    output START, NUM_BLOCKS, STALL, COUNT_Q,
    input  COUNT_WE, COUNT_D, ROW_VALID, ROW_IDX, BUSY, DONE
  );

  modport slave (
    input  START, NUM_BLOCKS, STALL, COUNT_Q,
    output COUNT_WE, COUNT_D, ROW_VALID, ROW_IDX, BUSY, DONE
  );
endinterface

// File: rtl/blk_row_cnt.sv
// Row counter within a block: synchronous clear, count enable, and a flag
// marking the last row.
module blk_row_cnt #(
  parameter int ROWS  = 8,
  parameter int ROW_W = 3
) (
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  input  logic             clr_s,
  input  logic             en_s,
  output logic [ROW_W-1:0] row_r,
  output logic             tc_s
);
  localparam logic [ROW_W-1:0] LAST_ROW_C = ROW_W'(ROWS - 1);

  assign tc_s = (row_r == LAST_ROW_C);

  // Row register: wraps to zero after the last row so no out-of-range index exists.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      row_r <= {ROW_W{1'b0}};
    end else if (clr_s) begin
      row_r <= {ROW_W{1'b0}};
    end else if (en_s) begin
      if (tc_s) begin
        row_r <= {ROW_W{1'b0}};
      end else begin
        row_r <= row_r + {{(ROW_W-1){1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: rtl/block_seq_ctrl.sv
// Frame sequencer: walks NUM_BLOCKS+1 blocks of ROWS rows each, driving an
// external block-index register and issuing one row per unstalled cycle.
module block_seq_ctrl
  import interp_ctrl_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int ROW_W = 3
) (
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  block_seq_ctrl_if.slave  bus
);
  state_e             state_r;
  state_e             state_nxt_s;
  logic [BLK_W-1:0]   last_r;
  logic [ROW_W-1:0]   row_s;
  logic               row_tc_s;
  logic               row_clr_s;
  logic               row_en_s;

  blk_row_cnt #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_row_cnt (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .clr_s       (row_clr_s),
    .en_s        (row_en_s),
    .row_r       (row_s),
    .tc_s        (row_tc_s)
  );

  // State register and the last-block index captured on an accepted START.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_r <= S_IDLE;
      last_r  <= {BLK_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == S_IDLE) && bus.START) begin
        last_r <= bus.NUM_BLOCKS;
      end
    end
  end

  // Next-state logic; the frame ends after the last row of the block whose index matches last_r.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.START) begin
          state_nxt_s = S_CLEAR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR:  state_nxt_s = S_RUN;
      S_RUN: begin
        if (!bus.STALL && row_tc_s) begin
          if (bus.COUNT_Q == last_r) begin
            state_nxt_s = S_FINISH;
          end else begin
            state_nxt_s = S_NEXT;
          end
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_NEXT:   state_nxt_s = S_RUN;
      S_FINISH: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Moore output decode; only ROW_VALID and the row enable see STALL directly.
  always_comb begin
    bus.COUNT_WE  = 1'b0;
    bus.COUNT_D   = {BLK_W{1'b0}};
    bus.ROW_VALID = 1'b0;
    bus.ROW_IDX   = {ROW_W{1'b0}};
    bus.DONE      = 1'b0;
    bus.BUSY      = (state_r != S_IDLE);
    row_clr_s     = 1'b0;
    row_en_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        row_clr_s = 1'b0;
      end
      S_CLEAR: begin
        bus.COUNT_WE = 1'b1;
        row_clr_s    = 1'b1;
      end
      S_RUN: begin
        bus.ROW_VALID = !bus.STALL;
        bus.ROW_IDX   = row_s;
        row_en_s      = !bus.STALL;
      end
      S_NEXT: begin
        bus.COUNT_WE = 1'b1;
        bus.COUNT_D  = bus.COUNT_Q + 4'd1;
        row_clr_s    = 1'b1;
      end
      S_FINISH: begin
        bus.DONE = 1'b1;
      end
      default: begin
        row_clr_s = 1'b0;
      end
    endcase
  end
endmodule

// File: doc/block_seq_ctrl.md
BLOCK_SEQ_CTRL -- requirements
Module: block_seq_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8: rows processed per block, range 2..16.
REQ-002 SHALL have parameter ROW_W, default 3: ROW_IDX width, equal to clog2(ROWS).
REQ-003 SHALL have port CLK  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_ASYNC_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  in  1  one-cycle request to process a frame of blocks.
REQ-006 SHALL have port NUM_BLOCKS  in  4  index of the last block (blocks = NUM_BLOCKS+1); sampled only on an accepted START.
REQ-007 SHALL have port STALL  in  1  downstream not ready; freezes row progress.
REQ-008 SHALL have port COUNT_Q  in  4  current value of the external block-index register, fed back.
REQ-009 SHALL have port COUNT_WE  out  1  write enable to the block-index register.
REQ-010 SHALL have port COUNT_D  out  4  next block index for the block-index register.
REQ-011 SHALL have port ROW_VALID  out  1  current row is issued this cycle.
REQ-012 SHALL have port ROW_IDX  out  ROW_W  row within the current block.
REQ-013 SHALL have port BUSY  out  1  high in every state except IDLE.
REQ-014 SHALL have port DONE  out  1  one-cycle pulse when the last block completes.

Function
REQ-015 SHALL implement the FSM states IDLE, CLEAR, RUN, NEXT and FINISH.
REQ-016 SHALL, in IDLE with START=1, latch NUM_BLOCKS into last_q and move to CLEAR; START SHALL be ignored in all other states.
REQ-017 SHALL, in CLEAR, drive COUNT_WE=1 and COUNT_D=0, clear the row counter and move to RUN.
REQ-018 SHALL, in RUN, drive ROW_VALID=!STALL and ROW_IDX=row counter.
REQ-019 SHALL, in RUN, increment the row counter only when STALL=0.
REQ-020 SHALL, in RUN when row=ROWS-1 and STALL=0, move to FINISH if COUNT_Q==last_q, otherwise move to NEXT.
REQ-021 SHALL, in NEXT, drive COUNT_WE=1 and COUNT_D=COUNT_Q+1 (4-bit), clear the row counter and move to RUN.
REQ-022 SHALL, in FINISH, drive DONE=1 for exactly one cycle and return to IDLE.
REQ-023 SHALL decode all outputs from the registered state and counters only (Moore); outputs SHALL carry no combinational path from the inputs, except ROW_VALID from STALL.
REQ-024 SHALL hold COUNT_WE=0, COUNT_D=0 and ROW_VALID=0 outside CLEAR, NEXT and RUN respectively.
REQ-025 SHALL satisfy this no-stall timing, with START accepted at cycle t: CLEAR at t+1; block k rows at t+2+k(ROWS+1) onward; DONE at t+1+(NUM_BLOCKS+1)(ROWS+1).
REQ-026 SHALL, with NUM_BLOCKS=15, never produce COUNT_D wrap to 0 via increment; COUNT_D SHALL stop at 15.
REQ-027 SHALL, with NUM_BLOCKS=0, process one block with no NEXT state.
REQ-028 SHALL, when STALL=1 on the last row, hold RUN with ROW_IDX=ROWS-1 until STALL=0.
REQ-029 SHALL, when START coincides with FINISH, ignore START; a new START is accepted only from IDLE.
REQ-030 SHALL ignore changes on NUM_BLOCKS after acceptance; last_q governs.

Reset
REQ-031 SHALL, on RST_ASYNC_N=0 (including mid-frame), immediately force state=IDLE, row counter=0 and last_q=0, giving BUSY=0, DONE=0, COUNT_WE=0, COUNT_D=0, ROW_VALID=0 and ROW_IDX=0.
REQ-032 SHALL resume only on the first rising CLK edge after reset deassertion; no pending START is retained.

Structure
REQ-033 SHALL place the state encoding (3-bit, one localparam per state) and BLK_W=4 in the shared package interp_ctrl_pkg.
REQ-034 SHALL place the row counter (clear, enable, terminal-count flag) in sub-module blk_row_cnt, parameterised by ROWS.
REQ-035 SHALL keep the block-index register external, connected via COUNT_WE/COUNT_D/COUNT_Q.

Verification
REQ-036 SHALL cover: ROWS=8, NUM_BLOCKS=1, START at t, no stall -> COUNT_WE at t+1 (D=0) and t+10 (D=1), ROW_VALID t+2..t+9 and t+11..t+18, DONE at t+19.
REQ-037 SHALL cover: NUM_BLOCKS=0 -> a single block of 8 rows, exactly one COUNT_WE (D=0), DONE at t+10.
REQ-038 SHALL cover: NUM_BLOCKS=15 -> COUNT_D sequence 0,1..15, never 0 after 15; DONE at t+145.
REQ-039 SHALL cover: STALL=1 for 3 cycles at ROW_IDX=7 of block 0 -> ROW_IDX holds 7, ROW_VALID=0 for those cycles, DONE delayed by 3.
REQ-040 SHALL cover: reset asserted in RUN of block 2 -> all outputs 0 asynchronously; a subsequent START restarts from CLEAR with COUNT_D=0.
REQ-041 SHALL cover: START repeated while BUSY and coincident with FINISH -> ignored, exactly one DONE.
